regfile_wb_arbiter: RTL
=======================

Name: regfile_wb_arbiter

Overview:
- Write-back side of the register-file write port. Merges two result sources into the single we/waddr/wdata port of the 32x32 register file.
  - ALU path: one result per cycle, fixed priority, never stalled.
  - Multi-cycle divider path: valid/ready handshake.
- Divider results are buffered in a small FIFO until a write slot is free.
- Flags reads that would see a stale value while a buffered write to that register is pending.
- Sits between the EX/MEM pipeline and the register file; the register-file write port is its only downstream.

Parameters:
- DEPTH, 2, number of divider FIFO entries (power of 2, minimum 2).
- CNT_W, 2, width of fifo_cnt; must hold the value DEPTH.

Ports:
- clk, input, 1, clock.
- rst, input, 1, reset: synchronous, active-high.
- alu_we, input, 1, ALU result valid this cycle.
- alu_waddr, input, 5, ALU destination register.
- alu_wdata, input, 32, ALU result.
- div_valid, input, 1, divider result offered.
- div_ready, output, 1, arbiter accepts the divider result.
- div_waddr, input, 5, divider destination register.
- div_wdata, input, 32, divider result.
- raddr1, input, 5, decode read address 1 (hazard check).
- raddr2, input, 5, decode read address 2 (hazard check).
- stall_req, output, 1, a decode read hits a pending buffered write.
- we, output, 1, register-file write enable (registered).
- waddr, output, 5, register-file write address (registered).
- wdata, output, 32, register-file write data (registered).
- fifo_cnt, output, CNT_W, current FIFO occupancy.

Behaviour:
- Reset (rst=1 at posedge clk):
  - we=0, waddr=0, wdata=0.
  - FIFO emptied: fifo_cnt=0, all entry-valid bits cleared, read and write pointers at 0.
  - Any write in flight is discarded.
  - While rst=1, div_ready=0 and stall_req=0.
- Handshake:
  - div_ready = (fifo_cnt < DEPTH), taken from the registered count only. A pop in the same cycle does not raise ready.
  - Transfer occurs when div_valid && div_ready at posedge.
- Push: on transfer, write {valid=1, div_waddr, div_wdata} at the write pointer.
  - If div_waddr==0, no entry is pushed, but the handshake still completes.
- Output slot (one per cycle, registered, so each source is 1 cycle from selection to we):
  - Priority 1: if alu_we && alu_waddr!=0, register the ALU result: we=1, waddr=alu_waddr, wdata=alu_wdata.
  - Priority 2: else if the FIFO is non-empty, pop the head. If its valid bit is 1, register it with we=1; if 0, pop it with we=0.
  - Otherwise we=0; waddr and wdata hold their previous values.
- WAW rule: an ALU write to register X clears the valid bit of every buffered entry whose address is X. The ALU result is program-newer.
  - An entry pushed in the same cycle is not cleared, because the divider result is newer.
- Latency without bypass:
  - Divider result: handshake cycle N, earliest pop N+1, we high in N+2.
  - ALU result: we high in N+1.
- Simultaneous push and pop: both happen. Count is unchanged, and both pointers advance and wrap modulo DEPTH.
- stall_req is combinational and is 1 when any valid FIFO entry has address == raddr1 or == raddr2 (address 0 excluded).
  - Stall on pending ALU writes is not required; the register file forwards same-cycle writes.
- Full FIFO with continuous ALU writes: div_ready stays 0 and the divider stalls. No overflow and no data loss.

Optional Feature:
- Macro WB_BYPASS_EN.
- Defined: if fifo_cnt==0 and there is no valid ALU write this cycle, an accepted divider result goes directly to the output register (we=1 in N+1) and is not pushed.
- Undefined: all divider results go through the FIFO (2-cycle minimum latency).

Test Plan:
- Reset:
  - Stimulus: rst=1 for 2 cycles with div_valid=1.
  - Required response: we=0, div_ready=0, fifo_cnt=0; nothing is written after release until new input.
- Divider only:
  - Stimulus: div result r5=0x00000007 accepted in cycle 10, ALU idle.
  - Required response: we=1, waddr=5, wdata=7 in cycle 12 (cycle 11 with WB_BYPASS_EN).
- Collision:
  - Stimulus: in cycle 10, ALU writes r3=0x11 and the divider offers r4=0x22.
  - Required response: r3 written in cycle 11 and r4 in cycle 12, fifo_cnt=1 after cycle 10.
- Full FIFO:
  - Stimulus: ALU writes every cycle; divider offers 3 results.
  - Required response: 2 accepted, then div_ready=0. After ALU goes idle, both are drained in order and the third is then accepted.
- WAW:
  - Stimulus: r8=0xAA is buffered, then the ALU writes r8=0xBB.
  - Required response: r8 ends as 0xBB; the popped stale entry gives we=0.
- Hazard:
  - Stimulus: r9 is buffered and raddr2=9.
  - Required response: stall_req=1. It drops to 0 in the cycle after the pop. raddr1=0 never stalls.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter for the 32x32 register file write port.
// Merges a never-stalled ALU result stream with a valid/ready divider stream.
// Divider results wait in a DEPTH-entry FIFO until the ALU leaves a slot free.
// A newer ALU write to a register invalidates buffered divider writes to it.
// stall_req flags decode reads that would otherwise see a stale value.
// Optional build macro WB_BYPASS_EN: when the FIFO is empty and the ALU is
// idle, an accepted divider result goes straight to the output register.
module regfile_wb_arbiter #(
    parameter int DEPTH = 2,
    parameter int CNT_W = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        alu_we,
    input  logic [4:0]  alu_waddr,
    input  logic [31:0] alu_wdata,
    input  logic        div_valid,
    output logic        div_ready,
    input  logic [4:0]  div_waddr,
    input  logic [31:0] div_wdata,
    input  logic [4:0]  raddr1,
    input  logic [4:0]  raddr2,
    output logic        stall_req,
    output logic        we,
    output logic [4:0]  waddr,
    output logic [31:0] wdata,
    output logic [CNT_W-1:0] fifo_cnt
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // Buffered divider results: valid bit, destination, data.
    logic              ent_v [DEPTH];
    logic [4:0]        ent_a [DEPTH];
    logic [31:0]       ent_d [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  cnt;

    logic alu_hit;
    logic xfer;
    logic bypass;
    logic push;
    logic pop;
    logic hit;

    // Handshake: a divider result transfers on a rising edge where both
    // div_valid and div_ready are high. div_ready depends only on the
    // registered occupancy, so a same-cycle pop never raises it, and
    // div_valid is never looked at when forming div_ready.
    assign div_ready = !rst && (cnt < CNT_W'(DEPTH));
    assign xfer      = div_valid && div_ready;

    // Writes to r0 are architecturally discarded, so they never claim the slot.
    assign alu_hit = alu_we && (alu_waddr != 5'd0);

`ifdef WB_BYPASS_EN
    assign bypass = xfer && (cnt == '0) && !alu_hit && (div_waddr != 5'd0);
`else
    assign bypass = 1'b0;
`endif

    // r0 results complete the handshake but are dropped.
    assign push = xfer && (div_waddr != 5'd0) && !bypass;
    assign pop  = !alu_hit && (cnt != '0);

    assign fifo_cnt = cnt;

    // Hazard detect: any still-valid buffered write to a register being read.
    always_comb begin
        hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ent_v[i] && (ent_a[i] != 5'd0) &&
                ((ent_a[i] == raddr1) || (ent_a[i] == raddr2))) begin
                hit = 1'b1;
            end
        end
    end

    assign stall_req = !rst && hit;

    // FIFO control: pointers, occupancy and per-entry valid bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                ent_v[i] <= 1'b0;
            end
        end else begin
            // The ALU result is program-newer than anything already buffered.
            for (int i = 0; i < DEPTH; i++) begin
                if (alu_hit && (ent_a[i] == alu_waddr)) begin
                    ent_v[i] <= 1'b0;
                end
            end
            // Popped slots are cleared so idle entries never raise stall_req.
            if (pop) begin
                ent_v[rd_ptr] <= 1'b0;
                rd_ptr        <= rd_ptr + 1'b1;
            end
            // A same-cycle push is newer than the ALU write, so it stays valid.
            if (push) begin
                ent_v[wr_ptr] <= 1'b1;
                wr_ptr        <= wr_ptr + 1'b1;
            end
            if (push && !pop) begin
                cnt <= cnt + 1'b1;
            end else if (!push && pop) begin
                cnt <= cnt - 1'b1;
            end
        end
    end

    // FIFO payload storage; needs no reset because valid bits gate its use.
    always_ff @(posedge clk) begin
        if (push) begin
            ent_a[wr_ptr] <= div_waddr;
            ent_d[wr_ptr] <= div_wdata;
        end
    end

    // Output slot: ALU first, then bypass, then FIFO head; stale heads drain silently.
    always_ff @(posedge clk) begin
        if (rst) begin
            we    <= 1'b0;
            waddr <= 5'd0;
            wdata <= 32'd0;
        end else if (alu_hit) begin
            we    <= 1'b1;
            waddr <= alu_waddr;
            wdata <= alu_wdata;
        end else if (bypass) begin
            we    <= 1'b1;
            waddr <= div_waddr;
            wdata <= div_wdata;
        end else if (pop) begin
            we <= ent_v[rd_ptr];
            if (ent_v[rd_ptr]) begin
                waddr <= ent_a[rd_ptr];
                wdata <= ent_d[rd_ptr];
            end
        end else begin
            we <= 1'b0;
        end
    end

endmodule
